// File: rtl/sdram_rd_pkg.sv
// Shared types and helpers for the SDRAM burst read sequencer.
// Holds the FSM state type, the burstcount width rule and the byte-shift rule.
package sdram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    FINISH  = 2'd3
  } rd_state_e;

  // Avalon burstcount must be able to represent MAX_BURST itself.
  function automatic int burstcount_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  // Shift that converts a word count into a byte offset.
  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Synchronous output FIFO for the read sequencer; head word is visible combinationally.
// Asynchronous active-high reset and a synchronous flush clear the occupancy.
module sdram_rd_fifo #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic [CNT_W-1:0]  free_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  // Explicit wrap so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (count_reg != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr_reg];
  assign empty      = (count_reg == '0);
  assign free_count = CNT_W'(DEPTH) - count_reg;

endmodule

// File: rtl/sdram_read_sequencer.sv
// Avalon-MM burst reader that streams num_words words from base_addr through a small FIFO.
// Define SDRAM_RD_TIMEOUT_EN to build the read watchdog that sets the sticky error flag.
module sdram_read_sequencer
  import sdram_rd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int MAX_BURST   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [LEN_W-1:0]                    num_words,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [ADDR_W-1:0]                   avm_address,
  output logic                                avm_read,
  output logic [burstcount_w(MAX_BURST)-1:0]  avm_burstcount,
  input  logic                                avm_waitrequest,
  input  logic [DATA_W-1:0]                   avm_readdata,
  input  logic                                avm_readdatavalid,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int BC_W   = burstcount_w(MAX_BURST);
  localparam int BSHIFT = byte_shift(DATA_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < MAX_BURST || TIMEOUT_CYC < 2 || DATA_W < 8) begin : g_bad_cfg
    $error("sdram_read_sequencer: inconsistent parameter set");
  end

  rd_state_e          state_reg;
  rd_state_e          state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic [LEN_W-1:0]   rem_after;
  logic [BC_W-1:0]    burst_reg;
  logic [BC_W-1:0]    beat_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               read_req;
  logic               issue_ack;
  logic               beat_in;
  logic               last_beat;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [CNT_W-1:0]   free_count;
  logic               wd_fire;

  function automatic logic [BC_W-1:0] clip_burst(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(MAX_BURST)) return BC_W'(MAX_BURST);
    return BC_W'(rem);
  endfunction

  assign rem_after = remaining_reg - LEN_W'(burst_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (num_words == '0) ? FINISH : ISSUE;
      ISSUE:   if (issue_ack) state_next = COLLECT;
      COLLECT: if (last_beat) state_next = (remaining_reg != '0) ? ISSUE : FINISH;
      FINISH:  if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wd_fire) state_next = IDLE;
  end

  // A burst is only requested once the FIFO can take all of it.
  always_comb begin
    read_req = 1'b0;
    if (state_reg == ISSUE && 32'(burst_reg) <= 32'(free_count)) read_req = 1'b1;
    issue_ack = read_req && !avm_waitrequest;
    beat_in   = (state_reg == COLLECT) && avm_readdatavalid;
    last_beat = beat_in && (beat_reg == BC_W'(1));
    fifo_pop  = !fifo_empty && out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      burst_reg     <= '0;
      beat_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          addr_reg      <= (base_addr >> BSHIFT) << BSHIFT;
          remaining_reg <= num_words;
          burst_reg     <= clip_burst(num_words);
          busy_reg      <= 1'b1;
        end
        ISSUE: if (issue_ack) begin
          addr_reg      <= addr_reg + (ADDR_W'(burst_reg) << BSHIFT);
          remaining_reg <= rem_after;
          burst_reg     <= clip_burst(rem_after);
          beat_reg      <= burst_reg;
        end
        COLLECT: if (beat_in) beat_reg <= beat_reg - BC_W'(1);
        FINISH: if (fifo_empty) begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
      if (wd_fire) begin
        done_reg <= 1'b1;
        busy_reg <= 1'b0;
      end
    end
  end

`ifdef SDRAM_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_reg;
  logic            error_reg;
  logic            wd_run;
  logic            wd_kick;

  assign wd_run  = read_req || (state_reg == COLLECT);
  assign wd_kick = (read_req && !avm_waitrequest) || avm_readdatavalid;
  assign wd_fire = wd_run && !wd_kick && (wd_reg == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_reg    <= '0;
      error_reg <= 1'b0;
    end else begin
      if (!wd_run || wd_kick || wd_fire) wd_reg <= '0;
      else                               wd_reg <= wd_reg + WD_W'(1);
      if (wd_fire)                             error_reg <= 1'b1;
      else if (state_reg == IDLE && start)     error_reg <= 1'b0;
    end
  end

  assign error = error_reg;
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  sdram_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (wd_fire),
    .push       (beat_in),
    .push_data  (avm_readdata),
    .pop        (fifo_pop),
    .head_data  (out_data),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign avm_address    = addr_reg;
  assign avm_burstcount = burst_reg;
  assign avm_read       = read_req;
  assign out_valid      = !fifo_empty;

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Scoreboard bench: expected words and bursts are queued at start, checked as the DUT produces them.
// The watchdog scenario runs only when SDRAM_RD_TIMEOUT_EN is defined.
module tb_sdram_read_sequencer;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int LEN_W       = 16;
  localparam int MAX_BURST   = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int TIMEOUT_CYC = 16;
  localparam int BC_W        = 4;
  localparam int LAT         = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              busy, done, error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  sdram_read_sequencer #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LEN_W (LEN_W), .MAX_BURST (MAX_BURST),
    .FIFO_DEPTH (FIFO_DEPTH), .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .base_addr (base_addr),
    .num_words (num_words), .busy (busy), .done (done), .error (error),
    .avm_address (avm_address), .avm_read (avm_read), .avm_burstcount (avm_burstcount),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid), .out_data (out_data),
    .out_valid (out_valid), .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  logic [31:0] exp_q[$];
  burst_t      burst_q[$];

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  // Memory / consumer model state
  int          wait_cfg = 0;
  bit          no_data = 0;
  bit          ready_en = 1;
  int          beats_sent = 0, pops = 0, occ = 0, occ_peak = 0, over_cnt = 0;
  int          reads_seen = 0, accepts = 0, done_cnt = 0;
  time         acc_time = 0;
  bit          req_active = 0;
  int          wait_left = 0;
  logic [31:0] hold_addr;
  logic [3:0]  hold_bc;
  int          beat_left = 0, delay = 0;
  logic [31:0] beat_addr;

  initial begin
    burst_t b;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    out_ready         = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        beats_sent = 0; pops = 0; beat_left = 0; req_active = 0;
        avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        continue;
      end
      if (avm_readdatavalid) beats_sent++;
      occ = beats_sent - pops;
      if (occ > occ_peak) occ_peak = occ;
      if (done) begin
        done_cnt++;
        beat_left = 0;
        req_active = 0;
      end
      // consumer side
      out_ready = ready_en;
      if (out_valid && out_ready) begin
        check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("data", out_data, exp_q.pop_front());
        pops++;
      end
      // read data return for the outstanding burst
      avm_readdatavalid = 1'b0;
      if (beat_left > 0 && !no_data) begin
        if (delay > 1) delay--;
        else begin
          avm_readdatavalid = 1'b1;
          avm_readdata = mem_word(beat_addr);
          beat_addr += 32'd4;
          beat_left--;
        end
      end
      // command side
      if (avm_read) begin
        reads_seen++;
        if (occ + int'(avm_burstcount) > FIFO_DEPTH) over_cnt++;
        if (!req_active) begin
          req_active = 1;
          wait_left  = wait_cfg;
          hold_addr  = avm_address;
          hold_bc    = avm_burstcount;
        end else begin
          check_eq("addr_stable", avm_address, hold_addr);
          check_eq("bc_stable", 32'(avm_burstcount), 32'(hold_bc));
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          req_active = 0;
          accepts++;
          acc_time = $time;
          check_eq("burst_expected", 32'(burst_q.size() != 0), 32'd1);
          if (burst_q.size() != 0) begin
            b = burst_q.pop_front();
            check_eq("burst_addr", avm_address, b.addr);
            check_eq("burst_len", 32'(avm_burstcount), 32'(b.len));
          end
          beat_left = int'(avm_burstcount);
          beat_addr = avm_address;
          delay     = LAT;
        end
      end else begin
        req_active = 0;
        avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] addr, input int n, input bit expect_it);
    logic [31:0] a;
    int rem, bl;
    burst_t b;
    @(negedge clk);
    start = 1'b1;
    base_addr = addr;
    num_words = n[15:0];
    if (expect_it) begin
      a = addr & ~32'h3;
      for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a + 32'(i * 4)));
      rem = n;
      while (rem > 0) begin
        bl = (rem < MAX_BURST) ? rem : MAX_BURST;
        b.addr = a;
        b.len  = bl;
        burst_q.push_back(b);
        a += 32'(bl * 4);
        rem -= bl;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int i;
    i = 0;
    while (i < limit && !done) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0, r0, a0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_read", 32'(avm_read), 32'd0);
    check_eq("rst_addr", avm_address, 32'd0);
    check_eq("rst_bc", 32'(avm_burstcount), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;

    // 20 words from an unaligned base: bursts 8/8/4
    d0 = done_cnt;
    pulse_start(32'h1000_0003, 20, 1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 2000);
    repeat (2) @(negedge clk);
    check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_bursts_left", 32'(burst_q.size()), 32'd0);
    check_eq("t1_busy_low", 32'(busy), 32'd0);
    check_eq("t1_error", 32'(error), 32'd0);

    // zero-length transfer
    r0 = reads_seen;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_1234; num_words = '0;
    @(negedge clk);
    start = 1'b0;
    check_eq("z_busy_c1", 32'(busy), 32'd1);
    check_eq("z_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("z_done_c2", 32'(done), 32'd1);
    check_eq("z_busy_c2", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("z_no_read", 32'(reads_seen - r0), 32'd0);

    // waitrequest held for 5 cycles
    wait_cfg = 5;
    a0 = accepts;
    pulse_start(32'h2000_0100, 8, 1);
    wait_done("t3", 2000);
    wait_cfg = 0;
    check_eq("t3_accepts", 32'(accepts - a0), 32'd1);

    // backpressure: out_ready low for 40 cycles during a 32-word read
    repeat (2) @(negedge clk);
    ready_en = 0;
    occ_peak = 0;
    over_cnt = 0;
    d0 = done_cnt;
    pulse_start(32'h3000_0000, 32, 1);
    repeat (40) @(negedge clk);
    check_eq("bp_peak", 32'(occ_peak), 32'(FIFO_DEPTH));
    check_eq("bp_no_overissue", 32'(over_cnt), 32'd0);
    check_eq("bp_no_early_done", 32'(done_cnt - d0), 32'd0);
    check_eq("bp_still_busy", 32'(busy), 32'd1);
    ready_en = 1;
    wait_done("t4", 3000);
    repeat (2) @(negedge clk);
    check_eq("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // second start while busy is ignored
    d0 = done_cnt;
    pulse_start(32'h4000_0010, 12, 1);
    repeat (3) @(negedge clk);
    pulse_start(32'h5000_0000, 5, 0);
    wait_done("t5", 2000);
    r0 = reads_seen;
    repeat (20) @(negedge clk);
    check_eq("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t5_no_extra_read", 32'(reads_seen - r0), 32'd0);
    check_eq("t5_bursts_left", 32'(burst_q.size()), 32'd0);

    // reset while collecting, then a fresh transfer
    pulse_start(32'h6000_0000, 16, 1);
    for (int i = 0; i < 200 && !avm_readdatavalid; i++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mr_read", 32'(avm_read), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    check_eq("mr_addr", avm_address, 32'd0);
    check_eq("mr_bc", 32'(avm_burstcount), 32'd0);
    @(negedge clk);
    #1;
    exp_q.delete();
    burst_q.delete();
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    pulse_start(32'h7000_0040, 12, 1);
    wait_done("t6", 2000);
    repeat (2) @(negedge clk);
    check_eq("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t6_bursts_left", 32'(burst_q.size()), 32'd0);

`ifdef SDRAM_RD_TIMEOUT_EN
    // read data never returns: watchdog fires TIMEOUT_CYC cycles after acceptance
    no_data = 1;
    pulse_start(32'h8000_0000, 8, 1);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check_eq("to_done_seen", 32'(done), 32'd1);
    check_eq("to_error", 32'(error), 32'd1);
    // acceptance decision is one negedge before the accepting edge
    check_eq("to_latency", 32'(($time - acc_time) / 10), 32'(TIMEOUT_CYC + 1));
    @(negedge clk);
    check_eq("to_valid", 32'(out_valid), 32'd0);
    no_data = 0;
    exp_q.delete();
    burst_q.delete();
    pulse_start(32'h8000_0100, 4, 1);
    check_eq("to_error_cleared", 32'(error), 32'd0);
    wait_done("t7", 2000);
    check_eq("t7_error", 32'(error), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_read_sequencer.md
# sdram_read_sequencer

Sequences Avalon-MM burst reads from SDRAM when the HPS-side read trigger (`do_read`) fires. It fetches `num_words` words starting at `base_addr` and delivers them in order on a valid/ready stream to the image-processing datapath. A small output FIFO absorbs read latency, and bursts are issued only when the FIFO can hold a whole burst, so backpressure never stalls the SDRAM bus mid-burst.

## Interface
- `ADDR_W`, 32, byte address width of the Avalon master.
- `DATA_W`, 32, data word width; must be a power of two ≥ 8.
- `LEN_W`, 16, width of the word count.
- `MAX_BURST`, 8, maximum burst length in words; must be a power of two.
- `FIFO_DEPTH`, 16, output FIFO depth in words; must be ≥ `MAX_BURST`.
- `TIMEOUT_CYC`, 1024, watchdog limit in cycles (only used with the timeout macro).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle trigger; driven by `do_read`.
- `base_addr` in ADDR_W: start byte address; sampled on an accepted `start`.
- `num_words` in LEN_W: number of words to read; sampled on an accepted `start`.
- `busy` out 1: high from an accepted `start` until the `done` pulse.
- `done` out 1: one-cycle pulse when the transfer completes.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `avm_address` out ADDR_W: Avalon-MM read address.
- `avm_read` out 1: Avalon-MM read request.
- `avm_burstcount` out $clog2(MAX_BURST)+1: burst length in words.
- `avm_waitrequest` in 1: Avalon-MM wait request.
- `avm_readdata` in DATA_W: read data.
- `avm_readdatavalid` in 1: read data valid.
- `out_data` out DATA_W: stream data (FIFO head).
- `out_valid` out 1: stream valid; high when the FIFO is not empty.
- `out_ready` in 1: stream ready; a word is popped when `out_valid && out_ready`.

## Operation
- States: IDLE, ISSUE, COLLECT, FINISH.
- IDLE:
  - `start` latches `base_addr` (low $clog2(DATA_W/8) bits forced to 0) and `num_words` into `remaining`.
  - Clears `error` and sets `busy`.
  - If `num_words == 0`, go to FINISH; otherwise go to ISSUE.
- ISSUE:
  - `blen = min(MAX_BURST, remaining)`.
  - Assert `avm_read` only when FIFO free space ≥ `blen`. Otherwise keep `avm_read` low and stay in ISSUE.
  - Once asserted, `avm_read`, `avm_address` and `avm_burstcount` stay stable until a cycle with `!avm_waitrequest`.
  - In that cycle: address advances by `blen*DATA_W/8`, `remaining -= blen`, beat counter loads `blen`, next state is COLLECT.
- COLLECT:
  - Each `avm_readdatavalid` pushes `avm_readdata` into the FIFO and decrements the beat counter.
  - On the last beat: go to ISSUE if `remaining != 0`, else go to FINISH.
- FINISH: when the FIFO is empty, pulse `done`, drop `busy`, return to IDLE.
- Exactly one burst is outstanding at a time.
- The FIFO never overflows, because space for `blen` is reserved before issue.
- `start` while `busy` is ignored.
- Address arithmetic wraps modulo 2^ADDR_W with no error.
- A simultaneous FIFO push and pop in the same cycle leaves the occupancy unchanged.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty.
- Reset mid-transfer drops `avm_read` immediately (asynchronously), flushes the FIFO, and discards any in-flight beats.
- `busy` rises the cycle after `start`.
- `avm_read` can first assert in that same cycle (ISSUE is entered one cycle after `start`).
- `out_valid` rises the cycle after the first pushed beat.
- `done` fires the cycle after the FIFO becomes empty in FINISH.
- With `num_words == 0`, `done` fires 2 cycles after `start`.
- All outputs are registered except `out_data`, `out_valid` and `avm_read`, which are decoded from registered state only.

## Configuration
- Macro: `SDRAM_RD_TIMEOUT_EN`.
- Defined:
  - A watchdog counter runs in ISSUE (while `avm_read` is asserted) and in COLLECT.
  - It resets on every `!avm_waitrequest` and every `avm_readdatavalid`.
  - On reaching `TIMEOUT_CYC`: set `error`, drop `avm_read`, flush the FIFO, pulse `done`, return to IDLE.
- Not defined: no counter is built, `error` is tied to 0, and the sequencer waits indefinitely.

## Structure
- Package `sdram_rd_pkg` holds:
  - the state enum `rd_state_e`;
  - the burstcount width function;
  - the byte-shift constant derived from `DATA_W`.
- Sub-module `sdram_rd_fifo`:
  - synchronous FIFO with `DATA_W` width and `FIFO_DEPTH` depth;
  - ports: push, pop, `free_count`, empty, with asynchronous active-high reset.

## Test plan
- Default parameters, `base_addr=0x1000_0003`, `num_words=20`, `out_ready=1`, memory latency 3:
  - bursts at 0x1000_0000 (8), 0x1000_0020 (8), 0x1000_0040 (4);
  - 20 words out in order;
  - one `done` pulse.
- `num_words=0`: no `avm_read`; `busy` high for 1 cycle; `done` at cycle 2.
- `avm_waitrequest` held for 5 cycles: address and burstcount stable throughout; exactly one burst accepted.
- `out_ready=0` for 40 cycles during a 32-word read: FIFO peaks at ≤16 words; ISSUE holds `avm_read` low; no data lost; `done` only after drain.
- Second `start` while busy: ignored. Reset asserted in COLLECT: all outputs 0 next edge; a fresh `start` then completes normally.
- With `SDRAM_RD_TIMEOUT_EN`, `TIMEOUT_CYC=16`, `readdatavalid` never returned: `error=1` and `done` pulse after 16 cycles; the next `start` clears `error`.
